// File: rtl/wb_mux_stage_if.sv
// Write-back stage bus: request side (in_*, src/sel/rd) and result side (out_*, wb_*).
// Load-alignment signals exist only when WB_LOAD_EXT_EN is defined.
interface wb_mux_stage_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SEL_W = 2
);
  logic                  in_valid;
  logic                  in_ready;
  logic [NSRC*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]      sel;
  logic [4:0]            rd_addr;
  logic                  rd_we;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      wb_data;
  logic [4:0]            wb_addr;
  logic                  wb_we;
  logic                  sel_err;
  logic [31:0]           wb_count;
`ifdef WB_LOAD_EXT_EN
  logic [1:0]            ld_size;
  logic                  ld_unsigned;
  logic [1:0]            byte_off;
`endif

  // Pipeline side: issues requests and sinks results.
  modport master (
    output in_valid, src_data, sel, rd_addr, rd_we, out_ready,
    input  in_ready, out_valid, wb_data, wb_addr, wb_we, sel_err, wb_count
`ifdef WB_LOAD_EXT_EN
    , output ld_size, ld_unsigned, byte_off
`endif
  );

  // Stage side.
  modport slave (
    input  in_valid, src_data, sel, rd_addr, rd_we, out_ready,
    output in_ready, out_valid, wb_data, wb_addr, wb_we, sel_err, wb_count
`ifdef WB_LOAD_EXT_EN
    , input ld_size, ld_unsigned, byte_off
`endif
  );
endinterface

// File: rtl/wb_mux_stage.sv
// Registered NSRC-way write-back selector with a two-entry (OUT + SKID) buffer.
// Define WB_LOAD_EXT_EN to align and extend load data on source 1.
module wb_mux_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NSRC  = 4,
  parameter int unsigned SEL_W = 2
) (
  input logic           clk,
  input logic           rst,
  wb_mux_stage_if.slave wb_io
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [4:0]       addr;
    logic             we;
    logic             err;
  } entry_t;

  entry_t           in_entry;
  entry_t           out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [31:0]      count_q, count_d;
  logic             hit;
  logic [WIDTH-1:0] raw;
  logic             accept, advance;
`ifdef WB_LOAD_EXT_EN
  logic [WIDTH-1:0] shifted;
`endif

  always_comb begin
    hit = 1'b0;
    raw = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (wb_io.sel == SEL_W'(i)) begin
        hit = 1'b1;
        raw = wb_io.src_data[i*WIDTH +: WIDTH];
      end
    end
`ifdef WB_LOAD_EXT_EN
    shifted = raw >> {wb_io.byte_off, 3'b000};
    if (wb_io.sel == SEL_W'(1)) begin
      case (wb_io.ld_size)
        2'd0: raw = wb_io.ld_unsigned ? {{(WIDTH-8){1'b0}}, shifted[7:0]}
                                      : {{(WIDTH-8){shifted[7]}}, shifted[7:0]};
        2'd1: raw = wb_io.ld_unsigned ? {{(WIDTH-16){1'b0}}, shifted[15:0]}
                                      : {{(WIDTH-16){shifted[15]}}, shifted[15:0]};
        default: raw = raw;
      endcase
    end
`endif
    in_entry.data = hit ? raw : '0;
    in_entry.addr = wb_io.rd_addr;
    in_entry.we   = wb_io.rd_we && hit && (wb_io.rd_addr != 5'd0);
    in_entry.err  = !hit;
  end

  // in_ready is the registered !skid_valid, so out_ready never reaches it combinationally.
  assign accept  = wb_io.in_valid && !skid_valid_q;
  assign advance = !out_valid_q || wb_io.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    count_d      = count_q + 32'(out_valid_q && wb_io.out_ready && out_q.we);
    if (advance) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      count_q      <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      count_q      <= count_d;
    end
  end

  assign wb_io.in_ready  = !skid_valid_q;
  assign wb_io.out_valid = out_valid_q;
  assign wb_io.wb_data   = out_q.data;
  assign wb_io.wb_addr   = out_q.addr;
  assign wb_io.wb_we     = out_q.we;
  assign wb_io.sel_err   = out_q.err;
  assign wb_io.wb_count  = count_q;

endmodule

// File: tb/tb_wb_mux_stage.sv
// Directed bench for wb_mux_stage (NSRC=3 so sel=3 is an invalid select).
// Load-extension cases run only when WB_LOAD_EXT_EN is defined.
module tb_wb_mux_stage;
  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  wb_mux_stage_if #(.WIDTH(32), .NSRC(3), .SEL_W(2)) bus ();

  wb_mux_stage #(.WIDTH(32), .NSRC(3), .SEL_W(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .wb_io (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Selected slot gets d, the others get ~d so a wrong select is visible.
  task automatic drive(input logic [1:0] s, input logic [4:0] a, input logic we,
                       input logic [31:0] d);
    bus.in_valid = 1'b1;
    bus.sel      = s;
    bus.rd_addr  = a;
    bus.rd_we    = we;
    bus.src_data = {~d, ~d, ~d};
    if (s < 2'd3) bus.src_data[s*32 +: 32] = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++;
      $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    n_tests++; if (bus.wb_data !== 32'h0) begin n_fail++;
      $display("FAIL reset_wb_data got %h exp 0", bus.wb_data); end
    n_tests++; if (bus.wb_addr !== 5'd0 || bus.wb_we !== 1'b0 || bus.sel_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_addr_we_err got %0d/%b/%b exp 0/0/0",
                         bus.wb_addr, bus.wb_we, bus.sel_err); end
    n_tests++; if (bus.wb_count !== 32'd0) begin n_fail++;
      $display("FAIL reset_count got %0d exp 0", bus.wb_count); end
  endtask

  task automatic test_streaming;
    bus.out_ready = 1'b1;
    drive(2'd0, 5'd5, 1'b1, 32'h0000_1234);
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== 32'h1234 || bus.wb_addr !== 5'd5
                   || bus.wb_we !== 1'b1) begin n_fail++;
      $display("FAIL stream_first got v=%b d=%h a=%0d we=%b exp v=1 d=1234 a=5 we=1",
               bus.out_valid, bus.wb_data, bus.wb_addr, bus.wb_we); end
    tick();
    exp_cnt = 1;
    n_tests++; if (bus.wb_count !== 32'(exp_cnt) || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL stream_count got %0d v=%b exp %0d v=0", bus.wb_count, bus.out_valid,
               exp_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [1:0]  sels [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    logic [31:0] datas[4] = '{32'hA000_0001, 32'hB000_0002, 32'hC000_0003, 32'hD000_0004};
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(sels[k], 5'(k + 1), 1'b1, datas[k]);
      tick();
      n_tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== datas[k]
                     || bus.wb_addr !== 5'(k + 1) || bus.in_ready !== 1'b1) begin n_fail++;
        $display("FAIL b2b_%0d got v=%b d=%h a=%0d rdy=%b exp v=1 d=%h a=%0d rdy=1", k,
                 bus.out_valid, bus.wb_data, bus.wb_addr, bus.in_ready, datas[k], k + 1); end
    end
    bus.in_valid = 1'b0;
    tick();
    exp_cnt += 4;
    n_tests++; if (bus.wb_count !== 32'(exp_cnt) || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL b2b_count got %0d v=%b exp %0d v=0", bus.wb_count, bus.out_valid,
               exp_cnt); end
  endtask

  task automatic test_stall;
    logic [31:0] exp_d[3] = '{32'h0000_AAAA, 32'h0000_BBBB, 32'h0000_CCCC};
    bus.out_ready = 1'b0;
    drive(2'd0, 5'd10, 1'b1, exp_d[0]);
    tick();
    drive(2'd1, 5'd11, 1'b1, exp_d[1]);
    tick();
    n_tests++; if (bus.in_ready !== 1'b0 || bus.wb_data !== exp_d[0]) begin n_fail++;
      $display("FAIL stall_full got rdy=%b d=%h exp rdy=0 d=%h", bus.in_ready, bus.wb_data,
               exp_d[0]); end
    drive(2'd2, 5'd12, 1'b1, exp_d[2]);
    tick();
    n_tests++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.wb_data !== exp_d[0]
                   || bus.wb_addr !== 5'd10) begin n_fail++;
      $display("FAIL stall_hold got rdy=%b v=%b d=%h a=%0d exp rdy=0 v=1 d=%h a=10",
               bus.in_ready, bus.out_valid, bus.wb_data, bus.wb_addr, exp_d[0]); end
    bus.out_ready = 1'b1;
    tick();
    n_tests++; if (bus.wb_data !== exp_d[1] || bus.wb_addr !== 5'd11 || bus.in_ready !== 1'b1)
      begin n_fail++;
      $display("FAIL stall_drain_b got d=%h a=%0d rdy=%b exp d=%h a=11 rdy=1", bus.wb_data,
               bus.wb_addr, bus.in_ready, exp_d[1]); end
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.wb_data !== exp_d[2] || bus.wb_addr !== 5'd12 || bus.out_valid !== 1'b1)
      begin n_fail++;
      $display("FAIL stall_drain_c got d=%h a=%0d v=%b exp d=%h a=12 v=1", bus.wb_data,
               bus.wb_addr, bus.out_valid, exp_d[2]); end
    tick();
    exp_cnt += 3;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.wb_count !== 32'(exp_cnt)) begin n_fail++;
      $display("FAIL stall_count got v=%b cnt=%0d exp v=0 cnt=%0d", bus.out_valid,
               bus.wb_count, exp_cnt); end
  endtask

  task automatic test_x0_invalid;
    bus.out_ready = 1'b1;
    drive(2'd0, 5'd0, 1'b1, 32'h0000_ABCD);
    tick();
    n_tests++; if (bus.wb_we !== 1'b0 || bus.wb_data !== 32'hABCD || bus.sel_err !== 1'b0)
      begin n_fail++;
      $display("FAIL x0 got we=%b d=%h err=%b exp we=0 d=abcd err=0", bus.wb_we,
               bus.wb_data, bus.sel_err); end
    drive(2'd3, 5'd7, 1'b1, 32'h1234_5678);
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b1 || bus.wb_data !== 32'h0 || bus.sel_err !== 1'b1
                   || bus.wb_we !== 1'b0 || bus.wb_addr !== 5'd7) begin n_fail++;
      $display("FAIL badsel got v=%b d=%h err=%b we=%b a=%0d exp v=1 d=0 err=1 we=0 a=7",
               bus.out_valid, bus.wb_data, bus.sel_err, bus.wb_we, bus.wb_addr); end
    tick();
    n_tests++; if (bus.wb_count !== 32'(exp_cnt) || bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL x0_badsel_count got %0d v=%b exp %0d v=0", bus.wb_count,
               bus.out_valid, exp_cnt); end
  endtask

`ifdef WB_LOAD_EXT_EN
  task automatic test_load_ext;
    bus.out_ready   = 1'b1;
    drive(2'd1, 5'd3, 1'b1, 32'h80FF_7F01);
    bus.ld_size     = 2'd0;
    bus.ld_unsigned = 1'b0;
    bus.byte_off    = 2'd3;
    tick();
    n_tests++; if (bus.wb_data !== 32'hFFFF_FF80) begin n_fail++;
      $display("FAIL ld_byte_s got %h exp ffffff80", bus.wb_data); end
    bus.ld_size     = 2'd1;
    bus.ld_unsigned = 1'b1;
    bus.byte_off    = 2'd2;
    tick();
    n_tests++; if (bus.wb_data !== 32'h0000_80FF) begin n_fail++;
      $display("FAIL ld_half_u got %h exp 000080ff", bus.wb_data); end
    bus.ld_size     = 2'd3;
    bus.byte_off    = 2'd0;
    tick();
    bus.in_valid    = 1'b0;
    bus.ld_size     = 2'd2;
    n_tests++; if (bus.wb_data !== 32'h80FF_7F01) begin n_fail++;
      $display("FAIL ld_word got %h exp 80ff7f01", bus.wb_data); end
    tick();
    exp_cnt += 3;
  endtask
`else
  task automatic test_load_ext;
    bus.out_ready = 1'b1;
    drive(2'd1, 5'd3, 1'b1, 32'h80FF_7F01);
    tick();
    bus.in_valid = 1'b0;
    n_tests++; if (bus.wb_data !== 32'h80FF_7F01) begin n_fail++;
      $display("FAIL src1_raw got %h exp 80ff7f01", bus.wb_data); end
    tick();
    exp_cnt += 1;
  endtask
`endif

  task automatic test_reset_mid_stall;
    n_tests++; if (bus.wb_count !== 32'(exp_cnt)) begin n_fail++;
      $display("FAIL pre_reset_count got %0d exp %0d", bus.wb_count, exp_cnt); end
    bus.out_ready = 1'b0;
    drive(2'd0, 5'd20, 1'b1, 32'h0000_0020);
    tick();
    drive(2'd0, 5'd21, 1'b1, 32'h0000_0021);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b1;
    tick();
    rst     = 1'b0;
    exp_cnt = 0;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1
                   || bus.wb_count !== 32'd0) begin n_fail++;
      $display("FAIL reset_mid_stall got v=%b rdy=%b cnt=%0d exp v=0 rdy=1 cnt=0",
               bus.out_valid, bus.in_ready, bus.wb_count); end
    tick();
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_no_replay got v=%b exp 0", bus.out_valid); end
  endtask

  task automatic test_counter_wrap;
    bus.out_ready = 1'b1;
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    n_tests++; if (bus.wb_count !== 32'hFFFF_FFFF) begin n_fail++;
      $display("FAIL wrap_preload got %h exp ffffffff", bus.wb_count); end
    @(posedge clk);
    #1;
    drive(2'd0, 5'd9, 1'b1, 32'h0000_0009);
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_tests++; if (bus.wb_count !== 32'd0) begin n_fail++;
      $display("FAIL wrap got %h exp 0", bus.wb_count); end
  endtask

  initial begin
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.src_data  = '0;
    bus.sel       = '0;
    bus.rd_addr   = '0;
    bus.rd_we     = 1'b0;
    bus.out_ready = 1'b0;
`ifdef WB_LOAD_EXT_EN
    bus.ld_size     = 2'd2;
    bus.ld_unsigned = 1'b0;
    bus.byte_off    = 2'd0;
`endif
    test_reset();
    test_streaming();
    test_back_to_back();
    test_stall();
    test_x0_invalid();
    test_load_ext();
    test_reset_mid_stall();
    test_counter_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
